// File: rtl/seq_add_pkg.sv
// Shared constants, state encoding and condition-code helpers for the
// digit-serial 64-bit adder (seq_add_64).
package seq_add_pkg;

    localparam int N      = 64;          // operand / result width
    localparam int CHUNK  = 8;           // bits added per RUN cycle
    localparam int NCHUNK = N / CHUNK;   // RUN cycles per operation
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    // Y86 condition codes from the operand sign bits and the final sum.
    // The B sign is the effective (possibly inverted) operand.
    function automatic cc_t calc_cc(input logic a_msb, input logic b_eff_msb,
                                    input logic [N-1:0] s);
        cc_t cc;
        cc.zf = (s == '0);
        cc.sf = s[N-1];
        cc.of = (a_msb == b_eff_msb) && (s[N-1] != a_msb);
        return cc;
    endfunction

endpackage

// File: rtl/seq_add_64_if.sv
// Start/busy/done bus between the execute-stage sequencer (master) and the
// serial adder (slave). The op signal exists only when SEQ_ADD_SUB_MODE_EN
// is defined.
//
// Handshake: the slave samples start only while busy=0 (IDLE or the DONE
// cycle); on that edge a/b(/op) are captured and busy rises for exactly
// NCHUNK cycles. done is a one-cycle pulse; sum and flags are valid from the
// done cycle on and are held until the next completion. start during busy=1
// is ignored, there is no abort.
interface seq_add_64_if;
    import seq_add_pkg::*;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef SEQ_ADD_SUB_MODE_EN
    logic         op;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         zf;
    logic         sf;
    logic         of;

    modport master (
        output start, a, b,
`ifdef SEQ_ADD_SUB_MODE_EN
        output op,
`endif
        input  busy, done, sum, cout, zf, sf, of
    );

    modport slave (
        input  start, a, b,
`ifdef SEQ_ADD_SUB_MODE_EN
        input  op,
`endif
        output busy, done, sum, cout, zf, sf, of
    );

endinterface

// File: rtl/seq_add_64_add_chunk.sv
// Combinational W-bit full adder; the single slice adder that seq_add_64
// time-multiplexes across all operand slices.
module add_chunk
    import seq_add_pkg::*;
#(
    parameter int W = CHUNK
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         co
);

    // Widen by one bit so the slice carry-out falls out of the add.
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_add_64.sv
// seq_add_64: multi-cycle digit-serial adder for the Y86-64 sequential ALU.
// One CHUNK-bit slice is added per cycle with a registered carry; the result
// plus cout/zf/sf/of are registered on entry to DONE.
// Optional macro SEQ_ADD_SUB_MODE_EN adds an op input (op=1 computes a-b).
module seq_add_64
    import seq_add_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    seq_add_64_if.slave bus,
    output state_e      state_dbg
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;       // effective B (inverted for subtract)
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    cc_t              cc_q, cc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N-1:0]     b_in;
    logic             cin_in;
    logic [CHUNK-1:0] x_slice, y_slice, s_slice;
    logic             co_slice;

    // Effective B operand and carry-in for the operation being accepted.
`ifdef SEQ_ADD_SUB_MODE_EN
    assign b_in   = bus.op ? ~bus.b : bus.b;
    assign cin_in = bus.op;
`else
    assign b_in   = bus.b;
    assign cin_in = 1'b0;
`endif

    // Current slice of the captured operands feeds the shared slice adder.
    assign x_slice = a_q[idx_q*CHUNK +: CHUNK];
    assign y_slice = b_q[idx_q*CHUNK +: CHUNK];

    add_chunk #(.W(CHUNK)) u_add_chunk (
        .x   (x_slice),
        .y   (y_slice),
        .cin (carry_q),
        .s   (s_slice),
        .co  (co_slice)
    );

    // Next-state / datapath: accept in IDLE or DONE, one slice per RUN cycle,
    // publish result and flags on the final slice.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        cc_d    = cc_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[idx_q*CHUNK +: CHUNK] = s_slice;
                carry_d = co_slice;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = co_slice;
                    cc_d    = calc_cc(a_q[N-1], b_q[N-1], acc_d);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            cc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            cc_q    <= cc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.zf    = cc_q.zf;
    assign bus.sf    = cc_q.sf;
    assign bus.of    = cc_q.of;
    assign state_dbg = state_q;

endmodule
